// File: rtl/multi_pulse_stretcher.sv
// multi_pulse_stretcher
//   Multi-channel pulse stretcher for status/activity indicators. Each channel
//   stretches input events to at least `period` clk cycles (0 behaves as 1).
//   Each channel has its own mode:
//   - level mode: out stays high for max(input high time, period).
//   - retrigger mode: one-shot of `period` cycles, restarted by every rising edge.
//
// Parameters:
//   CHANNELS  number of independent channels (>= 1)
//   BITS      width of the per-channel counter and of `period`
//
// Ports:
//   clk     system clock, all logic on the rising edge
//   reset   synchronous active-low reset
//   in      per-channel event inputs
//   mode    per-channel mode: 0 = level, 1 = retrigger (sampled every cycle)
//   period  shared stretch length in clk cycles
//   out     registered stretched outputs
//   active  registered OR of all out bits, aligned with out
//
// Build option:
//   MULTI_PULSE_STRETCHER_SYNC_EN  when defined, each input passes through a
//   two-flop synchroniser (adds 2 cycles of latency); otherwise `in` is used
//   directly and must be synchronous to clk.
module multi_pulse_stretcher #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned BITS     = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] mode,
  input  logic [BITS-1:0]     period,
  output logic [CHANNELS-1:0] out,
  output logic                active
);

  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] s_prev_q, s_prev_d;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                active_q, active_d;
  logic [BITS-1:0]     cnt_q [CHANNELS];
  logic [BITS-1:0]     cnt_d [CHANNELS];
  logic [BITS-1:0]     p_len;
  logic [CHANNELS-1:0] idle;
  logic [CHANNELS-1:0] terminal;

`ifdef MULTI_PULSE_STRETCHER_SYNC_EN
  logic [CHANNELS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = in;
`endif

  assign s_prev_d = s;
  assign rise     = s & ~s_prev_q;
  assign p_len    = (period == '0) ? BITS'(1) : period;

  always_comb begin
    out_d    = '0;
    idle     = '0;
    terminal = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]    = cnt_q[i];
      idle[i]     = (cnt_q[i] == '0);
      // >= so a period lowered mid-pulse ends the pulse at the next edge
      terminal[i] = !idle[i] && (cnt_q[i] >= p_len);
      if (!mode[i]) begin
        if (idle[i]) begin
          if (s[i]) begin
            out_d[i] = 1'b1;
            cnt_d[i] = BITS'(1);
          end
        end else if (!terminal[i]) begin
          out_d[i] = 1'b1;
          cnt_d[i] = cnt_q[i] + BITS'(1);
        end else if (s[i]) begin
          out_d[i] = 1'b1;  // hold at terminal count while input stays high
        end else begin
          cnt_d[i] = '0;
        end
      end else begin
        if (idle[i]) begin
          if (rise[i]) begin
            out_d[i] = 1'b1;
            cnt_d[i] = BITS'(1);
          end
        end else if (!terminal[i]) begin
          out_d[i] = 1'b1;
          cnt_d[i] = rise[i] ? BITS'(1) : cnt_q[i] + BITS'(1);
        end else if (rise[i]) begin
          out_d[i] = 1'b1;
          cnt_d[i] = BITS'(1);
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
    active_d = |out_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_prev_q <= '0;
      out_q    <= '0;
      active_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      s_prev_q <= s_prev_d;
      out_q    <= out_d;
      active_q <= active_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out    = out_q;
  assign active = active_q;

endmodule
